complex_multiply_acc: RTL

Pipelined complex multiply-accumulate for the baseband datapath, successor to the single-product complex multiplier. Each accepted sample carries two complex operands whose scaled product (optionally against the conjugate of the second operand) is summed over a frame of up to LENGTH samples, and one complex sum is emitted per frame. Used for correlation, channel estimation and dot products ahead of the equalizer. Both streams use valid/ready handshakes.

---
 rtl/complex_multiply_acc.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/complex_multiply_acc.sv
// Pipelined complex multiply-accumulate: one scaled complex sum per frame of up to LENGTH products.
// Define COMPLEX_MULTIPLY_ACC_SATURATE_EN to clamp the output instead of wrapping it.
module complex_multiply_acc #(
   parameter int WIDTH  = 16,
   parameter int LENGTH = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [1:0][2*WIDTH-1:0]       s_data,
   input  logic                          s_conj,
   input  logic                          s_last,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [4*WIDTH-1:0]            m_data,
   output logic                          m_sat
);

   localparam int PW  = 2*WIDTH;
   localparam int ACC = PW + $clog2(LENGTH);
   localparam int CW  = (LENGTH > 1) ? $clog2(LENGTH) : 1;

   logic en;
   logic v1, v2, v3;
   logic conj1, conj2, last1, last2, last3;
   logic signed [WIDTH-1:0] a_re, a_im, b_re, b_im;
   logic signed [PW-1:0]    pp_rr, pp_ii, pp_ri, pp_ir;
   logic signed [PW:0]      re_wide, im_wide;
   logic signed [PW-1:0]    p_re, p_im;
   logic signed [ACC-1:0]   acc_re, acc_im, sum_re, sum_im;
   logic signed [PW-1:0]    nar_re, nar_im;
   logic [CW-1:0]           cnt;
   logic                    frame_end;

   // A held output freezes the whole pipeline so nothing in flight is lost.
   assign en      = !m_valid || m_ready;
   assign s_ready = en;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
         conj1 <= 1'b0; conj2 <= 1'b0;
         last1 <= 1'b0; last2 <= 1'b0; last3 <= 1'b0;
         a_re <= '0; a_im <= '0; b_re <= '0; b_im <= '0;
         pp_rr <= '0; pp_ii <= '0; pp_ri <= '0; pp_ir <= '0;
         p_re <= '0; p_im <= '0;
      end else if (en) begin
         v1    <= s_valid;
         conj1 <= s_conj;
         last1 <= s_last;
         a_re  <= s_data[0][WIDTH-1:0];
         a_im  <= s_data[0][PW-1:WIDTH];
         b_re  <= s_data[1][WIDTH-1:0];
         b_im  <= s_data[1][PW-1:WIDTH];

         v2    <= v1;
         conj2 <= conj1;
         last2 <= last1;
         pp_rr <= PW'(a_re) * PW'(b_re);
         pp_ii <= PW'(a_im) * PW'(b_im);
         pp_ri <= PW'(a_re) * PW'(b_im);
         pp_ir <= PW'(a_im) * PW'(b_re);

         v3    <= v2;
         last3 <= last2;
         p_re  <= PW'(re_wide >>> 1);
         p_im  <= PW'(im_wide >>> 1);
      end
   end

   // One extra bit keeps the combine exact; the halving then always fits PW bits.
   always_comb begin
      if (conj2) begin
         re_wide = (PW+1)'(pp_rr) + (PW+1)'(pp_ii);
         im_wide = (PW+1)'(pp_ir) - (PW+1)'(pp_ri);
      end else begin
         re_wide = (PW+1)'(pp_rr) - (PW+1)'(pp_ii);
         im_wide = (PW+1)'(pp_ri) + (PW+1)'(pp_ir);
      end
   end

   assign sum_re    = acc_re + ACC'(p_re);
   assign sum_im    = acc_im + ACC'(p_im);
   assign frame_end = last3 || (cnt == CW'(LENGTH-1));

`ifdef COMPLEX_MULTIPLY_ACC_SATURATE_EN
   localparam logic signed [ACC-1:0] SAT_MAX = {{(ACC-PW+1){1'b0}}, {(PW-1){1'b1}}};
   localparam logic signed [ACC-1:0] SAT_MIN = ~SAT_MAX;
   logic sat_re, sat_im;

   always_comb begin
      sat_re = 1'b0;
      sat_im = 1'b0;
      nar_re = PW'(sum_re);
      nar_im = PW'(sum_im);
      if (sum_re > SAT_MAX) begin
         nar_re = PW'(SAT_MAX); sat_re = 1'b1;
      end else if (sum_re < SAT_MIN) begin
         nar_re = PW'(SAT_MIN); sat_re = 1'b1;
      end
      if (sum_im > SAT_MAX) begin
         nar_im = PW'(SAT_MAX); sat_im = 1'b1;
      end else if (sum_im < SAT_MIN) begin
         nar_im = PW'(SAT_MIN); sat_im = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         m_sat <= 1'b0;
      else if (en && v3 && frame_end)
         m_sat <= sat_re || sat_im;
   end
`else
   assign nar_re = PW'(sum_re);
   assign nar_im = PW'(sum_im);
   assign m_sat  = 1'b0;
`endif

   // A closing product goes straight to the output together with the running sum.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_re  <= '0;
         acc_im  <= '0;
         cnt     <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (en) begin
         m_valid <= v3 && frame_end;
         if (v3) begin
            if (frame_end) begin
               m_data <= {nar_im, nar_re};
               acc_re <= '0;
               acc_im <= '0;
               cnt    <= '0;
            end else begin
               acc_re <= sum_re;
               acc_im <= sum_im;
               cnt    <= cnt + CW'(1);
            end
         end
      end
   end

endmodule
